// File: rtl/trail_map.sv
// Shadow occupancy store for the game field: records every plotted pixel and answers per-cell lookups.
// Latency: lookup result one cycle after acceptance; a full-field clear sweep takes WIDTH*HEIGHT cycles.
// Backpressure: q_ready is low for the whole sweep; plots are dropped and queries get no response meanwhile.
//
// Ports:
//   clk, resetn            clock and synchronous active-low reset
//   clear                  single-cycle request to re-blank the field
//   plot, x, y, colour     pixel write bus shared with the VGA adapter
//   q_valid, q_x, q_y      lookup request; accepted when q_valid && q_ready
//   q_ready                high whenever no sweep is in progress
//   r_valid                one-cycle pulse per accepted lookup
//   r_colour               stored colour of the queried cell (0 when out of bounds)
//   r_occupied             cell is non-black, or the query is out of bounds
//   r_oob                  queried coordinate lies outside the field
//   busy                   clear sweep in progress
//   clear_done             one-cycle pulse on the first idle cycle after a sweep
module trail_map #(
   parameter int WIDTH  = 100,
   parameter int HEIGHT = 100,
   parameter int XW     = 7,
   parameter int YW     = 7,
   parameter int CW     = 3
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          clear,
   input  logic          plot,
   input  logic [XW-1:0] x,
   input  logic [YW-1:0] y,
   input  logic [CW-1:0] colour,
   input  logic          q_valid,
   input  logic [XW-1:0] q_x,
   input  logic [YW-1:0] q_y,
   output logic          q_ready,
   output logic          r_valid,
   output logic [CW-1:0] r_colour,
   output logic          r_occupied,
   output logic          r_oob,
   output logic          busy,
   output logic          clear_done
);

   localparam int CELLS = WIDTH * HEIGHT;
   localparam int AW    = $clog2(CELLS);
   localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);

   typedef enum logic {
      S_CLEAR,
      S_IDLE
   } state_t;

   state_t        state;
   logic [AW-1:0] sweep_addr;

   logic [CW-1:0] mem [CELLS];

   // Row-major cell addresses; AW bits hold every in-range address exactly.
   logic [AW-1:0] w_addr;
   logic [AW-1:0] q_addr;
   logic          w_in_range;
   logic          q_in_range;

   assign w_addr     = AW'(y) * AW'(WIDTH) + AW'(x);
   assign q_addr     = AW'(q_y) * AW'(WIDTH) + AW'(q_x);
   assign w_in_range = (int'(x) < WIDTH) && (int'(y) < HEIGHT);
   assign q_in_range = (int'(q_x) < WIDTH) && (int'(q_y) < HEIGHT);

   assign busy    = (state == S_CLEAR);
   assign q_ready = (state == S_IDLE);

   // Single write port: the sweep owns it during CLEAR, the plot bus otherwise.
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [CW-1:0] mem_wdat;

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = w_addr;
      mem_wdat  = colour;
      if (resetn) begin
         if (state == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_addr;
            mem_wdat  = '0;
         end else begin
            mem_we = plot && w_in_range;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdat;
      end
   end

   // Sweep control. A clear during a sweep just rewinds the address counter.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= S_CLEAR;
         sweep_addr <= '0;
         clear_done <= 1'b0;
      end else begin
         clear_done <= 1'b0;
         case (state)
            S_CLEAR: begin
               if (clear) begin
                  sweep_addr <= '0;
               end else if (sweep_addr == LAST_ADDR) begin
                  state      <= S_IDLE;
                  sweep_addr <= '0;
                  clear_done <= 1'b1;
               end else begin
                  sweep_addr <= sweep_addr + 1'b1;
               end
            end
            default: begin
               if (clear) begin
                  state      <= S_CLEAR;
                  sweep_addr <= '0;
               end
            end
         endcase
      end
   end

   // Lookup response. A same-cycle plot to the queried cell is forwarded so
   // the player sees its own fresh trail without waiting for the array write.
   logic          q_accept;
   logic          bypass_hit;
   logic [CW-1:0] rd_colour;

   assign q_accept   = q_valid && (state == S_IDLE);
   assign bypass_hit = plot && w_in_range && (w_addr == q_addr);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_valid    <= 1'b0;
         r_colour   <= '0;
         r_occupied <= 1'b0;
         r_oob      <= 1'b0;
      end else begin
         r_valid <= q_accept;
         if (q_accept) begin
            if (!q_in_range) begin
               // Anything off the field is a wall.
               r_colour   <= '0;
               r_occupied <= 1'b1;
               r_oob      <= 1'b1;
            end else begin
               r_colour   <= rd_colour;
               r_occupied <= (rd_colour != '0);
               r_oob      <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      rd_colour = '0;
      if (q_in_range) begin
         rd_colour = bypass_hit ? colour : mem[q_addr];
      end
   end

endmodule

// File: tb/tb_trail_map.sv
// Directed bench for trail_map: reset/sweep timing, plot/lookup table, clear and mid-stream reset.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: sweep waits are bounded by a cycle budget.
module tb_trail_map;

   logic       clk;
   logic       resetn;
   logic       clear;
   logic       plot;
   logic [6:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       q_valid;
   logic [6:0] q_x;
   logic [6:0] q_y;
   logic       q_ready;
   logic       r_valid;
   logic [2:0] r_colour;
   logic       r_occupied;
   logic       r_oob;
   logic       busy;
   logic       clear_done;

   int checks = 0;
   int errors = 0;

   trail_map dut (
      .clk        (clk),
      .resetn     (resetn),
      .clear      (clear),
      .plot       (plot),
      .x          (x),
      .y          (y),
      .colour     (colour),
      .q_valid    (q_valid),
      .q_x        (q_x),
      .q_y        (q_y),
      .q_ready    (q_ready),
      .r_valid    (r_valid),
      .r_colour   (r_colour),
      .r_occupied (r_occupied),
      .r_oob      (r_oob),
      .busy       (busy),
      .clear_done (clear_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string name;
      logic  plot;
      int    x;
      int    y;
      int    colour;
      logic  q_valid;
      int    qx;
      int    qy;
      logic  e_valid;
      int    e_colour;
      int    e_occ;
      int    e_oob;
   } vec_t;

   vec_t tbl[14];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic query(input string nm, input int qx, input int qy,
                        input int ec, input int eo, input int eb);
      q_valid = 1'b1;
      q_x     = 7'(qx);
      q_y     = 7'(qy);
      step();
      q_valid = 1'b0;
      chk({nm, "_rvalid"}, 32'(r_valid), 1);
      chk({nm, "_colour"}, 32'(r_colour), 32'(ec));
      chk({nm, "_occ"}, 32'(r_occupied), 32'(eo));
      chk({nm, "_oob"}, 32'(r_oob), 32'(eb));
   endtask

   // Counts edges until busy drops; expects exactly 10000. Optionally plots
   // (1,1) part-way through, which must be dropped.
   task automatic run_sweep(input string nm, input bit do_plot);
      int  n    = 0;
      int  bad  = 0;
      bit  done = 1'b0;
      while (!done) begin
         step();
         n++;
         plot = 1'b0;
         if (do_plot && n == 500) begin
            plot   = 1'b1;
            x      = 7'd1;
            y      = 7'd1;
            colour = 3'd6;
         end
         if (busy) begin
            if (q_ready || r_valid || clear_done) bad++;
         end else begin
            done = 1'b1;
         end
         if (n >= 20000) done = 1'b1;
      end
      chk({nm, "_len"}, 32'(n), 10000);
      chk({nm, "_quiet"}, 32'(bad), 0);
      chk({nm, "_clear_done"}, 32'(clear_done), 1);
      chk({nm, "_q_ready"}, 32'(q_ready), 1);
   endtask

   initial begin
      resetn  = 1'b0;
      clear   = 1'b0;
      plot    = 1'b0;
      x       = '0;
      y       = '0;
      colour  = '0;
      q_valid = 1'b0;
      q_x     = '0;
      q_y     = '0;

      //            name        plot x   y   col qv qx  qy  ev ec eo eb
      tbl[0]  = '{"plot42",     1, 42, 17, 4,  0, 0,  0,  0, 0, 0, 0};
      tbl[1]  = '{"q42_17",     0, 0,  0,  0,  1, 42, 17, 1, 4, 1, 0};
      tbl[2]  = '{"q43_17",     0, 0,  0,  0,  1, 43, 17, 1, 0, 0, 0};
      tbl[3]  = '{"bypass55",   1, 5,  5,  2,  1, 5,  5,  1, 2, 1, 0};
      tbl[4]  = '{"oob_x100",   0, 0,  0,  0,  1, 100, 3, 1, 0, 1, 1};
      tbl[5]  = '{"oob_y127",   0, 0,  0,  0,  1, 3,  127, 1, 0, 1, 1};
      tbl[6]  = '{"plot_oob",   1, 100, 0, 7,  0, 0,  0,  0, 0, 0, 0};
      tbl[7]  = '{"q0_1",       0, 0,  0,  0,  1, 0,  1,  1, 0, 0, 0};
      tbl[8]  = '{"bypass9999", 1, 99, 99, 1,  1, 99, 99, 1, 1, 1, 0};
      tbl[9]  = '{"q99_99",     0, 0,  0,  0,  1, 99, 99, 1, 1, 1, 0};
      tbl[10] = '{"plot00_q10", 1, 0,  0,  7,  1, 1,  0,  1, 0, 0, 0};
      tbl[11] = '{"q0_0",       0, 0,  0,  0,  1, 0,  0,  1, 7, 1, 0};
      tbl[12] = '{"q5_5",       0, 0,  0,  0,  1, 5,  5,  1, 2, 1, 0};
      tbl[13] = '{"bypass77",   1, 7,  7,  3,  1, 7,  7,  1, 3, 1, 0};

      // Reset values.
      step();
      step();
      chk("rst_busy", 32'(busy), 1);
      chk("rst_q_ready", 32'(q_ready), 0);
      chk("rst_r_valid", 32'(r_valid), 0);
      chk("rst_r_colour", 32'(r_colour), 0);
      chk("rst_r_occ", 32'(r_occupied), 0);
      chk("rst_r_oob", 32'(r_oob), 0);
      chk("rst_clear_done", 32'(clear_done), 0);

      // Initial sweep with a query held pending at (0,0).
      q_valid = 1'b1;
      resetn  = 1'b1;
      run_sweep("init", 1'b0);
      step();
      q_valid = 1'b0;
      chk("init_q_rvalid", 32'(r_valid), 1);
      chk("init_q_colour", 32'(r_colour), 0);
      chk("init_q_occ", 32'(r_occupied), 0);
      chk("init_done_pulse", 32'(clear_done), 0);

      // Table of single-cycle plot/query vectors.
      for (int i = 0; i < 14; i++) begin
         plot    = tbl[i].plot;
         x       = 7'(tbl[i].x);
         y       = 7'(tbl[i].y);
         colour  = 3'(tbl[i].colour);
         q_valid = tbl[i].q_valid;
         q_x     = 7'(tbl[i].qx);
         q_y     = 7'(tbl[i].qy);
         step();
         chk({tbl[i].name, "_rvalid"}, 32'(r_valid), 32'(tbl[i].e_valid));
         if (tbl[i].e_valid) begin
            chk({tbl[i].name, "_colour"}, 32'(r_colour), 32'(tbl[i].e_colour));
            chk({tbl[i].name, "_occ"}, 32'(r_occupied), 32'(tbl[i].e_occ));
            chk({tbl[i].name, "_oob"}, 32'(r_oob), 32'(tbl[i].e_oob));
         end
      end
      plot    = 1'b0;
      q_valid = 1'b0;

      // Response fields hold after the pulse.
      step();
      chk("hold_rvalid", 32'(r_valid), 0);
      chk("hold_colour", 32'(r_colour), 3);

      // Clear request with a plot dropped mid-sweep.
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_busy", 32'(busy), 1);
      chk("clr_q_ready", 32'(q_ready), 0);
      run_sweep("clr", 1'b1);
      plot = 1'b0;
      query("clr_42_17", 42, 17, 0, 0, 0);
      query("clr_5_5", 5, 5, 0, 0, 0);
      query("clr_99_99", 99, 99, 0, 0, 0);
      query("clr_0_0", 0, 0, 0, 0, 0);
      query("clr_1_1", 1, 1, 0, 0, 0);

      // Streamed queries interrupted by reset.
      for (int k = 0; k < 4; k++) begin
         plot   = 1'b1;
         x      = 7'(10 + k);
         y      = 7'd10;
         colour = 3'(k + 1);
         step();
      end
      plot = 1'b0;
      for (int k = 0; k < 4; k++) begin
         q_valid = 1'b1;
         q_x     = 7'(10 + k);
         q_y     = 7'd10;
         if (k == 3) resetn = 1'b0;
         step();
         if (k < 3) begin
            chk($sformatf("stream%0d_rvalid", k), 32'(r_valid), 1);
            chk($sformatf("stream%0d_colour", k), 32'(r_colour), 32'(k + 1));
         end else begin
            chk("midrst_rvalid", 32'(r_valid), 0);
            chk("midrst_busy", 32'(busy), 1);
            chk("midrst_q_ready", 32'(q_ready), 0);
            chk("midrst_colour", 32'(r_colour), 0);
         end
      end
      q_valid = 1'b0;
      resetn  = 1'b1;
      run_sweep("rst2", 1'b0);
      query("rst2_13_10", 13, 10, 0, 0, 0);
      query("rst2_10_10", 10, 10, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/trail_map.md
# trail_map

Shadow occupancy store for the 100x100 game field. It sits on the same x/y/colour/plot write bus that feeds the VGA adapter and records every plotted pixel. It answers per-cell lookup queries so the player datapaths can detect collisions with trails and walls before moving. On reset or on request it sweeps the whole field to colour 0, matching the black background image.

## Interface
Parameters:
- WIDTH, 100, field columns
- HEIGHT, 100, field rows
- XW, 7, x coordinate width
- YW, 7, y coordinate width
- CW, 3, colour width (1 bit per channel, RGB)

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- resetn  in  1  reset; synchronous, active-low
- clear  in  1  single-cycle request to re-blank the field
- plot  in  1  write strobe, same bus as VGA adapter
- x  in  XW  write column
- y  in  YW  write row
- colour  in  CW  write colour
- q_valid  in  1  lookup request
- q_x  in  XW  lookup column
- q_y  in  YW  lookup row
- q_ready  out  1  lookup accepted this cycle when q_valid && q_ready
- r_valid  out  1  lookup result valid (one-cycle pulse per accepted query)
- r_colour  out  CW  stored colour of the queried cell
- r_occupied  out  1  cell is non-black, or the query is out of bounds
- r_oob  out  1  queried coordinate is outside the field
- busy  out  1  clear sweep in progress
- clear_done  out  1  one-cycle pulse when a sweep completes

## Operation
- Storage: WIDTH*HEIGHT entries of CW bits. Address = y*WIDTH + x, 14 bits, computed without truncation.
- States: CLEAR and IDLE.
  - CLEAR: an address counter starts at 0 and writes colour 0 at one address per cycle, up to WIDTH*HEIGHT-1; it then goes to IDLE.
  - IDLE: services plot writes and lookups.
- Reset: while resetn=0, the block is forced into CLEAR with the counter at 0. The sweep starts on the first cycle with resetn=1.
- clear=1 in IDLE: enter CLEAR next cycle with the counter at 0.
- clear=1 in CLEAR: restart the counter at 0.
- busy = (state == CLEAR). q_ready = !busy.
- In CLEAR:
  - plot writes are dropped.
  - q_valid is ignored; no response is produced.
- In IDLE, plot=1:
  - Writes colour to (x,y) when x<WIDTH and y<HEIGHT.
  - Out-of-range writes are dropped silently.
- Accepted query, result on the next cycle:
  - In range: r_colour = stored value, r_occupied = (r_colour != 0), r_oob = 0.
  - Out of range: r_oob = 1, r_occupied = 1 (walls collide), r_colour = 0.
- Same-cycle write and query to the same in-range cell: the response returns the newly written colour (write-through bypass).
- Back-to-back queries are accepted every cycle; responses stream one per cycle in order.
- Reset asserted while a response is pending: the response is discarded; r_valid=0 on the cycle after reset is sampled.

## Timing
- Reset values, registered on the reset cycle:
  - busy=1
  - q_ready=0
  - r_valid=0, r_colour=0, r_occupied=0, r_oob=0
  - clear_done=0
- Sweep length is exactly WIDTH*HEIGHT cycles (10000 at defaults).
  - Address 0 is written on cycle 1 after resetn rises (or after clear is sampled in IDLE).
  - Address 9999 is written on cycle 10000.
  - On cycle 10001: busy=0, q_ready=1, clear_done=1 for exactly one cycle.
- Query latency: 1 cycle from acceptance to r_valid. r_* fields are held stable until the next response; r_valid is high only on response cycles.
- A write in cycle N is visible to a query accepted in cycle N (bypass) and after.
- clear and plot sampled in the same IDLE cycle: the write is performed, then the sweep overwrites the cell.

## Test plan
- Release reset, hold q_valid=1 at (0,0) -> q_ready=0 for 10000 cycles. clear_done and q_ready rise on cycle 10001. The query is answered one cycle later with r_colour=0, r_occupied=0.
- After the sweep: plot (42,17) colour 3'b100, then query (42,17) -> next cycle r_valid=1, r_colour=3'b100, r_occupied=1, r_oob=0. Query (43,17) -> r_colour=0, r_occupied=0.
- Same cycle: plot (5,5) colour 3'b010 and query (5,5) -> response r_colour=3'b010.
- Query (100,3) and (3,127) -> r_oob=1, r_occupied=1, r_colour=0. Plot (100,0) colour 7 -> a later query of (0,1) (address 100) returns 0.
- Fill cells, pulse clear, plot (1,1) during the sweep -> busy=1 for 10000 cycles. All previously set cells read 0 afterwards, and (1,1) reads 0.
- Stream 4 queries on consecutive cycles, then assert resetn=0 mid-stream -> in-order responses before reset. r_valid=0 on the cycle after reset is sampled. busy=1 and the sweep restarts from address 0.
